cdc_mem_gray_sync: RTL and testbench
====================================

// Module: cdc_mem_gray_sync
// PURPOSE
//  Storage and pointer-crossing core of the async FIFO.
//  - 128x4 dual-address memory: write port plus combinational read port.
//  - 8-bit binary-to-Gray converter for the local FIFO pointer.
//  - 8-bit two-flop synchronizer for the Gray pointer arriving from the other clock domain.
//  Sits between the FIFO write/read pointer controllers and the Gray-to-binary decoders.
// PARAMETERS
//  DATA_W       4   memory word width
//  ADDR_W       7   address width; depth = 2**ADDR_W = 128
//  PTR_W        8   pointer width = ADDR_W+1 (MSB is the wrap bit)
//  SYNC_STAGES  2   synchronizer depth; legal values >= 2
// PORTS
//  clk       in   1       single clock; all state updates on the rising edge
//  rst       in   1       reset, synchronous, active-high
//  wclken    in   1       write enable
//  waddr     in   ADDR_W  write address
//  wdata     in   DATA_W  write data
//  raddr     in   ADDR_W  read address
//  rdata     out  DATA_W  read data
//  ptr_bin   in   PTR_W   local binary pointer
//  ptr_gray  out  PTR_W   Gray encoding of ptr_bin (combinational)
//  sync_in   in   PTR_W   Gray pointer from the foreign domain (asynchronous)
//  sync_out  out  PTR_W   synchronized copy of sync_in
// BEHAVIOUR
//  Reset:
//  - When rst=1 at a rising clk edge, all 128 memory words clear to 0.
//  - All synchronizer stages clear to 0.
//  - rst has priority over wclken; no write happens in a reset cycle.
//  - After reset, rdata=0 for every raddr and sync_out=0.
//  - ptr_gray has no state and follows ptr_bin at all times.
//  Write:
//  - On a rising edge with rst=0 and wclken=1: mem[waddr] <= wdata.
//  - No write when wclken=0. No full checking in this block; that is the controller's job.
//  Read:
//  - rdata = mem[raddr], combinational, zero-latency.
//  - rdata changes as soon as raddr changes.
//  - Same-address write: rdata shows the old word before the edge and the new word after the edge.
//  Gray:
//  - ptr_gray = ptr_bin ^ (ptr_bin >> 1). Pure combinational logic.
//  - Example: bin 8'h7F -> gray 8'h40. Bin FF -> gray 80. Bin 80 -> gray C0.
//  - Successive codes differ by 1 bit, including the wrap from FF to 00.
//  Synchronizer:
//  - Shift chain: s[0] <= sync_in, s[k] <= s[k-1]; sync_out = s[SYNC_STAGES-1].
//  - Latency is exactly SYNC_STAGES rising edges (2 by default).
//  - A value held stable on sync_in appears on sync_out 2 edges later.
//  - A reset mid-stream clears the chain; pre-reset values are never output afterwards.
//  Structure:
//  - No combinational path from sync_in to sync_out.
//  - Each stage is a plain flop; no logic between stages.
//  Addressing:
//  - waddr and raddr are used modulo depth; the pointer MSB is never an address bit.
// CONFIGURATION
//  RDATA_REG_EN
//  - Defined: rdata is registered.
//    - rdata <= mem[raddr] on each rising edge, giving 1-cycle read latency.
//    - rst clears the rdata register to 0.
//    - Same-address write and read in one edge returns the OLD word (read-before-write).
//  - Undefined: combinational read as described above.
// TESTING
//  1. Reset, then sweep raddr 0..127 -> rdata=0 at every address. Also sync_out=0.
//  2. Write wdata=A to waddr=5, then set raddr=5 -> rdata=A after the edge.
//     Then write with wclken=0, wdata=3 -> rdata stays A.
//  3. ptr_bin sweep 00..FF -> ptr_gray=bin^(bin>>1); spot-check 7F->40, FF->80, 80->C0.
//     Adjacent codes have Hamming distance 1.
//  4. sync_in=8'h3C applied before edge N -> sync_out=3C after edge N+1, not before.
//     Changing sync_in every cycle -> sync_out replays the sequence delayed 2 cycles.
//  5. rst=1 together with wclken=1, waddr=9, wdata=F -> mem[9] stays 0.
//     rst=1 mid-sync-stream -> sync_out=0 on the next edge.
//  6. With RDATA_REG_EN, write 7 to addr 2 while raddr=2 at the same edge -> rdata shows the old word.
//     The next edge -> rdata=7.

Source files
------------

// File: rtl/cdc_mem_gray_sync.sv
// Async-FIFO core: 2**ADDR_W x DATA_W memory, binary-to-Gray pointer encoder, Gray pointer synchronizer.
// Optional macro RDATA_REG_EN registers the read port (1-cycle latency, read-before-write).
module cdc_mem_gray_sync #(
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 7,
  parameter int PTR_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wclken,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [PTR_W-1:0]  ptr_bin,
  output logic [PTR_W-1:0]  ptr_gray,
  input  logic [PTR_W-1:0]  sync_in,
  output logic [PTR_W-1:0]  sync_out
);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sync [SYNC_STAGES];

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wclken) begin
      r_mem[waddr] <= wdata;
    end
  end

`ifdef RDATA_REG_EN
  logic [DATA_W-1:0] r_rdata;

  // Registered read samples the pre-edge word, so a colliding write returns old data.
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
`else
  assign rdata = r_mem[raddr];
`endif

  assign ptr_gray = bin2gray(ptr_bin);

  // Plain flop chain: no logic between stages, sync_in never reaches sync_out combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= sync_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_cdc_mem_gray_sync.sv
// Directed bench for cdc_mem_gray_sync: memory reset/write/read, Gray encoding, synchronizer latency and reset.
module tb_cdc_mem_gray_sync;

  logic       clk;
  logic       rst;
  logic       wclken;
  logic [6:0] waddr;
  logic [3:0] wdata;
  logic [6:0] raddr;
  logic [3:0] rdata;
  logic [7:0] ptr_bin;
  logic [7:0] ptr_gray;
  logic [7:0] sync_in;
  logic [7:0] sync_out;

  int checks;
  int failures;

  cdc_mem_gray_sync dut (
    .clk      (clk),
    .rst      (rst),
    .wclken   (wclken),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .ptr_bin  (ptr_bin),
    .ptr_gray (ptr_gray),
    .sync_in  (sync_in),
    .sync_out (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [6:0] a, input logic [3:0] exp, input string tag);
    raddr = a;
`ifdef RDATA_REG_EN
    tick();
`else
    #1;
`endif
    chk(tag, {28'd0, rdata}, {28'd0, exp});
  endtask

  task automatic wr(input logic [6:0] a, input logic [3:0] d);
    wclken = 1'b1;
    waddr  = a;
    wdata  = d;
    tick();
    wclken = 1'b0;
  endtask

  logic [7:0] seq [8];
  logic [7:0] prev;
  logic [7:0] g_prev;
  logic [7:0] b;
  logic [7:0] exp_g;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wclken   = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr    = '0;
    ptr_bin  = '0;
    sync_in  = 8'hAA;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h44; seq[3] = 8'h88;
    seq[4] = 8'hFF; seq[5] = 8'h00; seq[6] = 8'h5A; seq[7] = 8'hA5;

    // 1. reset state
    tick();
    tick();
    chk("sync_out_in_reset", {24'd0, sync_out}, 32'h0);
    sync_in = 8'h00;
    rst     = 1'b0;
    tick();
    chk("sync_out_after_reset", {24'd0, sync_out}, 32'h0);
    for (int a = 0; a < 128; a++) rd(a[6:0], 4'h0, "rdata_reset_sweep");

    // 2. write / read / disabled write
    wr(7'd5, 4'hA);
    rd(7'd5, 4'hA, "rdata_addr5");
    wclken = 1'b0;
    waddr  = 7'd5;
    wdata  = 4'h3;
    tick();
    rd(7'd5, 4'hA, "rdata_no_write");
    wr(7'd0, 4'h1);
    wr(7'd127, 4'hE);
    wr(7'd64, 4'h6);
    rd(7'd0, 4'h1, "rdata_addr0");
    rd(7'd127, 4'hE, "rdata_addr127");
    rd(7'd64, 4'h6, "rdata_addr64");
    rd(7'd63, 4'h0, "rdata_addr63_untouched");
`ifndef RDATA_REG_EN
    raddr  = 7'd5;
    wclken = 1'b1;
    waddr  = 7'd5;
    wdata  = 4'h6;
    #1;
    chk("same_addr_before_edge", {28'd0, rdata}, 32'hA);
    tick();
    wclken = 1'b0;
    chk("same_addr_after_edge", {28'd0, rdata}, 32'h6);
`endif

    // 3. Gray encoder
    ptr_bin = 8'h7F; #1; chk("gray_7F", {24'd0, ptr_gray}, 32'h40);
    ptr_bin = 8'hFF; #1; chk("gray_FF", {24'd0, ptr_gray}, 32'h80);
    ptr_bin = 8'h80; #1; chk("gray_80", {24'd0, ptr_gray}, 32'hC0);
    ptr_bin = 8'h05; #1; chk("gray_05", {24'd0, ptr_gray}, 32'h07);
    ptr_bin = 8'hFF; #1;
    g_prev = ptr_gray;
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      ptr_bin = b;
      #1;
      exp_g = b ^ {1'b0, b[7:1]};
      chk("gray_sweep", {24'd0, ptr_gray}, {24'd0, exp_g});
      chk("gray_hamming", $countones(ptr_gray ^ g_prev), 32'd1);
      g_prev = ptr_gray;
    end

    // 4. synchronizer latency and replay
    sync_in = 8'h3C;
    tick();
    chk("sync_one_edge", {24'd0, sync_out}, 32'h0);
    tick();
    chk("sync_two_edges", {24'd0, sync_out}, 32'h3C);
    prev = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      sync_in = seq[i];
      tick();
      chk("sync_replay", {24'd0, sync_out}, {24'd0, prev});
      prev = seq[i];
    end

    // 5. reset priority over write; reset mid-stream
    rst    = 1'b1;
    wclken = 1'b1;
    waddr  = 7'd9;
    wdata  = 4'hF;
    tick();
    rst    = 1'b0;
    wclken = 1'b0;
    chk("sync_cleared_by_reset", {24'd0, sync_out}, 32'h0);
    rd(7'd9, 4'h0, "rdata_reset_blocks_write");
    rd(7'd5, 4'h0, "rdata_addr5_cleared");
    sync_in = 8'h77;
    tick();
    tick();
    chk("sync_77", {24'd0, sync_out}, 32'h77);
    sync_in = 8'h99;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sync_midstream_reset", {24'd0, sync_out}, 32'h0);
    tick();
    chk("sync_no_stale", {24'd0, sync_out}, 32'h0);
    tick();
    chk("sync_99", {24'd0, sync_out}, 32'h99);

`ifdef RDATA_REG_EN
    // 6. registered read-before-write
    raddr = 7'd2;
    tick();
    wclken = 1'b1;
    waddr  = 7'd2;
    wdata  = 4'h7;
    tick();
    wclken = 1'b0;
    chk("regread_old_word", {28'd0, rdata}, 32'h0);
    tick();
    chk("regread_new_word", {28'd0, rdata}, 32'h7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
